// File: rtl/demux4_stream_pkg.sv
// ============================================================================
//  Module   : demux4_stream_pkg
//  Purpose  : Shared constants and helpers for the 1-to-4 stream demultiplexer
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package demux4_stream_pkg;

    // Width of the channel select field
    localparam int SEL_W = 2;

    // One-hot decode of a channel select, gated by an enable
    function automatic logic [3:0] sel_onehot(input logic [SEL_W-1:0] sel, input logic en);
        logic [3:0] oh;
        oh = 4'b0000;
        if (en) begin
            oh[sel] = 1'b1;
        end
        return oh;
    endfunction

endpackage : demux4_stream_pkg

`default_nettype wire

// File: rtl/demux4_stream_slot.sv
// ============================================================================
//  Module   : stream_slot
//  Purpose  : One-entry holding register for a single demux output channel.
//             Load wins over drain so a same-cycle drain+reload keeps the
//             slot valid with the new payload; flush wins over both.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module stream_slot #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             drain_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    // Valid flag: flush clears, load sets, drain alone clears
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_o <= 1'b0;
        end else if (flush_i) begin
            valid_o <= 1'b0;
        end else if (load_i) begin
            valid_o <= 1'b1;
        end else if (drain_i) begin
            valid_o <= 1'b0;
        end
    end

    // Payload: captured only on a non-flushed load, otherwise held
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_o <= '0;
        end else if (load_i && !flush_i) begin
            data_o <= data_i;
        end
    end

endmodule : stream_slot

`default_nettype wire

// File: rtl/demux4_stream.sv
// ============================================================================
//  Module   : demux4_stream
//  Purpose  : 1-to-4 registered stream demultiplexer with valid/ready
//             handshake, per-channel one-entry slots, flush and a
//             saturating stall-cycle counter.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module demux4_stream
    import demux4_stream_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int STALL_W = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               flush_i,
    input  logic               valid_i,
    output logic               ready_o,
    input  logic [SEL_W-1:0]   sel_i,
    input  logic [WIDTH-1:0]   data_i,
    output logic [3:0]         valid_o,
    input  logic [3:0]         ready_i,
    output logic [WIDTH-1:0]   d0_o,
    output logic [WIDTH-1:0]   d1_o,
    output logic [WIDTH-1:0]   d2_o,
    output logic [WIDTH-1:0]   d3_o,
    output logic [STALL_W-1:0] stall_cnt_o
);

    localparam int NUM_CH = 4;

    logic              accept;
    logic [NUM_CH-1:0] load;
    logic [NUM_CH-1:0] drain;
    logic [WIDTH-1:0]  slot_data [NUM_CH];

    // Accept when not flushing and the addressed slot is empty or draining now
    always_comb begin
        ready_o = ~flush_i & (~valid_o[sel_i] | ready_i[sel_i]);
        accept  = valid_i & ready_o;
        load    = sel_onehot(sel_i, accept);
        drain   = valid_o & ready_i;
    end

    generate
        for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
            stream_slot #(
                .WIDTH (WIDTH)
            ) u_slot (
                .clk_i   (clk_i),
                .rst_i   (rst_i),
                .load_i  (load[k]),
                .drain_i (drain[k]),
                .flush_i (flush_i),
                .data_i  (data_i),
                .valid_o (valid_o[k]),
                .data_o  (slot_data[k])
            );
        end
    endgenerate

    assign d0_o = slot_data[0];
    assign d1_o = slot_data[1];
    assign d2_o = slot_data[2];
    assign d3_o = slot_data[3];

    // Count producer stall cycles, holding at all-ones instead of wrapping
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_o <= '0;
        end else if (valid_i && !ready_o && (stall_cnt_o != {STALL_W{1'b1}})) begin
            stall_cnt_o <= stall_cnt_o + STALL_W'(1);
        end
    end

endmodule : demux4_stream

`default_nettype wire
